// File: rtl/edge_pkg.sv
// Shared types and helpers for the Sobel front end.
//
// Contents:
//   PIX_W / GRAY_W / WIN_W : pixel, grey sample and 3x3 window widths.
//   state_t                : frame sequencer states.
//   win_t                  : 3x3 grey window, element 8 = top-left, 0 = bottom-right.
//   rgb2gray               : (R + 2G + B) >> 2 on a 10-bit sum.
package edge_pkg;

  localparam int PIX_W  = 24;
  localparam int GRAY_W = 8;
  localparam int WIN_W  = 72;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef logic [8:0][GRAY_W-1:0] win_t;

  // Largest possible sum is 255 + 510 + 255 = 1020, so ten bits hold it and
  // the shifted result always fits in eight bits.
  function automatic logic [GRAY_W-1:0] rgb2gray(input logic [PIX_W-1:0] rgb);
    logic [9:0] sum;
    sum = {2'b00, rgb[23:16]} + {1'b0, rgb[15:8], 1'b0} + {2'b00, rgb[7:0]};
    return GRAY_W'(sum >> 2);
  endfunction

endpackage

// File: rtl/line_buffer.sv
// One image row of grey samples.
//
// Ports:
//   clk     : system clock, rising edge
//   we      : write enable
//   addr    : column index, shared by read and write
//   wr_data : grey sample written at addr on the clock edge
//   rd_data : grey sample currently stored at addr (combinational)
//
// Contents are never reset; the window gating upstream masks anything left
// over from a previous frame.
module line_buffer
  import edge_pkg::*;
#(
  parameter int DEPTH = 2500,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [GRAY_W-1:0] wr_data,
  output logic [GRAY_W-1:0] rd_data
);

  logic [GRAY_W-1:0] mem [DEPTH];

  assign rd_data = mem[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wr_data;
    end
  end

endmodule

// File: rtl/sobel_window_buffer.sv
// Converts a raster stream of RGB pixels to grey and produces one 3x3 grey
// window per interior pixel of a W x H frame, (W-2)*(H-2) windows in total.
//
// Ports:
//   clk, n_rst              : clock (rising edge), asynchronous active-low reset
//   start                   : one-cycle pulse in IDLE, samples img_width/img_height
//   img_width, img_height   : frame dimensions
//   pixel_valid/data/ready  : RGB pixel input handshake, {R,G,B}
//   window_valid/data/ready : window output handshake, [71:64] top-left,
//                             raster order, [7:0] bottom-right
//   busy                    : frame in progress (state != IDLE)
//   frame_done              : one-cycle pulse after the final window is taken
//   size_err                : sticky until the next start, bad dimensions
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for start; pixels ignored
// RUN   | accepting pixels, emitting windows
// DRAIN | all pixels taken, waiting for the last window to be consumed
// DONE  | frame_done pulse (also reached directly on a size error)
module sobel_window_buffer #(
  parameter int MAX_WIDTH = 2500,
  parameter int DIM_W     = 16,
  parameter int PIX_W     = 24
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     start,
  input  logic [DIM_W-1:0]         img_width,
  input  logic [DIM_W-1:0]         img_height,
  input  logic                     pixel_valid,
  input  logic [PIX_W-1:0]         pixel_data,
  output logic                     pixel_ready,
  output logic                     window_valid,
  output logic [edge_pkg::WIN_W-1:0] window_data,
  input  logic                     window_ready,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     size_err
);

  import edge_pkg::*;

  localparam int               AW        = $clog2(MAX_WIDTH);
  localparam logic [DIM_W-1:0] MAX_W_DIM = DIM_W'(MAX_WIDTH);
  localparam logic [DIM_W-1:0] ONE       = DIM_W'(1);
  localparam logic [DIM_W-1:0] TWO       = DIM_W'(2);
  localparam logic [DIM_W-1:0] THREE     = DIM_W'(3);

  state_t state;

  logic [DIM_W-1:0]    w_last;
  logic [DIM_W-1:0]    h_last;
  logic [DIM_W-1:0]    col;
  logic [DIM_W-1:0]    row;
  // Window columns, each {top, mid, bottom}; col0 is the leftmost.
  logic [3*GRAY_W-1:0] col0;
  logic [3*GRAY_W-1:0] col1;
  logic [3*GRAY_W-1:0] col2;
  logic                wv;
  logic                size_err_q;

  logic                accept;
  logic                bad_dims;
  logic                win_gate;
  logic                col_last;
  logic                row_last;
  logic [GRAY_W-1:0]   gray;
  logic [GRAY_W-1:0]   lb0_rd;
  logic [GRAY_W-1:0]   lb1_rd;
  win_t                win;

  assign gray     = rgb2gray(pixel_data);
  assign bad_dims = (img_width < THREE) || (img_height < THREE) || (img_width > MAX_W_DIM);

  // A new pixel may only enter when the current window is not stuck; a
  // same-cycle window_ready lets the next window replace it without a bubble.
  assign pixel_ready = (state == RUN) && !(wv && !window_ready);
  assign accept      = pixel_valid && pixel_ready;

  assign col_last = (col == w_last);
  assign row_last = (row == h_last);
  // Columns 0 and 1 of a row would pull the previous row's tail into the
  // window, and rows 0 and 1 see stale line-buffer contents.
  assign win_gate = (row >= TWO) && (col >= TWO);

  line_buffer #(.DEPTH(MAX_WIDTH), .AW(AW)) lb0 (
    .clk     (clk),
    .we      (accept),
    .addr    (col[AW-1:0]),
    .wr_data (gray),
    .rd_data (lb0_rd)
  );

  line_buffer #(.DEPTH(MAX_WIDTH), .AW(AW)) lb1 (
    .clk     (clk),
    .we      (accept),
    .addr    (col[AW-1:0]),
    .wr_data (lb0_rd),
    .rd_data (lb1_rd)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      w_last     <= '0;
      h_last     <= '0;
      col        <= '0;
      row        <= '0;
      col0       <= '0;
      col1       <= '0;
      col2       <= '0;
      wv         <= 1'b0;
      size_err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            w_last <= img_width - ONE;
            h_last <= img_height - ONE;
            if (bad_dims) begin
              size_err_q <= 1'b1;
              state      <= DONE;
            end else begin
              size_err_q <= 1'b0;
              col        <= '0;
              row        <= '0;
              state      <= RUN;
            end
          end
        end

        RUN: begin
          if (accept) begin
            col0 <= col1;
            col1 <= col2;
            col2 <= {lb1_rd, lb0_rd, gray};
            wv   <= win_gate;
            if (col_last) begin
              col <= '0;
              row <= row + ONE;
              if (row_last) begin
                state <= DRAIN;
              end
            end else begin
              col <= col + ONE;
            end
          end else if (window_ready) begin
            wv <= 1'b0;
          end
        end

        DRAIN: begin
          if (!wv || window_ready) begin
            wv    <= 1'b0;
            state <= DONE;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign win = {col0[23:16], col1[23:16], col2[23:16],
                col0[15:8],  col1[15:8],  col2[15:8],
                col0[7:0],   col1[7:0],   col2[7:0]};

  assign window_valid = wv;
  assign window_data  = win;
  assign busy         = (state != IDLE);
  assign frame_done   = (state == DONE);
  assign size_err     = size_err_q;

endmodule

// File: tb/tb_sobel_window_buffer.sv
module tb_sobel_window_buffer;

  logic        tb_clk = 1'b0;
  logic        n_rst;
  logic        start;
  logic [15:0] img_width;
  logic [15:0] img_height;
  logic        pixel_valid;
  logic [23:0] pixel_data;
  logic        pixel_ready;
  logic        window_valid;
  logic [71:0] window_data;
  logic        window_ready;
  logic        busy;
  logic        frame_done;
  logic        size_err;

  always #5 tb_clk = ~tb_clk;

  sobel_window_buffer dut (
    .clk          (tb_clk),
    .n_rst        (n_rst),
    .start        (start),
    .img_width    (img_width),
    .img_height   (img_height),
    .pixel_valid  (pixel_valid),
    .pixel_data   (pixel_data),
    .pixel_ready  (pixel_ready),
    .window_valid (window_valid),
    .window_data  (window_data),
    .window_ready (window_ready),
    .busy         (busy),
    .frame_done   (frame_done),
    .size_err     (size_err)
  );

  int          errors = 0;
  int          checks = 0;
  logic [23:0] img[$];
  logic [71:0] exp_q[$];
  logic [71:0] exp_w;
  logic [71:0] hold_data;
  logic [71:0] first_win;
  logic [71:0] last_win;
  bit          chk_en = 0;
  bit          prev_hold = 0;
  bit          stall_done = 0;
  int          stall_cnt = 0;
  int          stall_seen = 0;
  int          done_pulses = 0;
  int          frame_win_cnt = 0;
  int          rdy_mode = 0;

  task automatic chk(input bit ok, input string name, input logic [71:0] act, input logic [71:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [7:0] gray_of(input logic [23:0] p);
    int s;
    s = int'(p[23:16]) + 2 * int'(p[15:8]) + int'(p[7:0]);
    return 8'(s / 4);
  endfunction

  // Every interior pixel (r,c) yields the 3x3 neighbourhood ending at it.
  task automatic build_expected(input int w, input int h);
    logic [71:0] win;
    exp_q.delete();
    for (int r = 2; r < h; r++) begin
      for (int c = 2; c < w; c++) begin
        win = '0;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            win[71 - 8 * (3 * i + j) -: 8] = gray_of(img[(r - 2 + i) * w + (c - 2 + j)]);
        exp_q.push_back(win);
      end
    end
  endtask

  task automatic gen_ramp(input int w, input int h);
    logic [7:0] v;
    img.delete();
    for (int k = 0; k < w * h; k++) begin
      v = 8'(k);
      img.push_back({v, v, v});
    end
  endtask

  task automatic gen_rand(input int w, input int h);
    img.delete();
    for (int k = 0; k < w * h; k++) img.push_back(24'($urandom));
  endtask

  // Downstream ready: 0 = always, 1 = random, 2 = hold low 5 cycles at first window.
  initial begin
    window_ready = 1'b1;
    forever begin
      @(posedge tb_clk);
      #1;
      if (rdy_mode == 2 && !stall_done && window_valid) begin
        stall_cnt  = 5;
        stall_done = 1;
      end
      if (stall_cnt > 0) begin
        window_ready = 1'b0;
        stall_cnt--;
      end else if (rdy_mode == 1) begin
        window_ready = 1'($urandom_range(0, 1));
      end else begin
        window_ready = 1'b1;
      end
    end
  end

  // Per-cycle compare against the model's window queue.
  initial begin
    forever begin
      @(negedge tb_clk);
      if (chk_en) begin
        if (prev_hold) chk(window_valid && window_data == hold_data, "window_hold", window_data, hold_data);
        prev_hold = window_valid && !window_ready;
        hold_data = window_data;
        if (window_valid && !window_ready) begin
          stall_seen++;
          chk(pixel_ready == 1'b0, "stall_pixel_ready", pixel_ready, 0);
        end
        if (!busy) chk(pixel_ready == 1'b0, "idle_pixel_ready", pixel_ready, 0);
        if (window_valid && window_ready) begin
          if (exp_q.size() == 0) begin
            chk(1'b0, "extra_window", window_data, 0);
          end else begin
            exp_w = exp_q.pop_front();
            chk(window_data == exp_w, "window_data", window_data, exp_w);
          end
          if (frame_win_cnt == 0) first_win = window_data;
          last_win = window_data;
          frame_win_cnt++;
        end
        if (frame_done) begin
          done_pulses++;
          chk(exp_q.size() == 0, "done_before_windows", exp_q.size(), 0);
        end
      end
    end
  end

  task automatic send_pixel(input logic [23:0] d);
    int n;
    n = 0;
    pixel_valid = 1'b1;
    pixel_data  = d;
    forever begin
      @(negedge tb_clk);
      if (pixel_ready) break;
      n++;
      if (n > 200) begin
        chk(1'b0, "pixel_accept_timeout", 0, 1);
        break;
      end
    end
    @(posedge tb_clk);
    #1;
    pixel_valid = 1'b0;
  endtask

  task automatic run_frame(input int w, input int h, input bit gaps, input int abort_after, input bit spurious);
    int d0;
    int n;
    build_expected(w, h);
    d0            = done_pulses;
    frame_win_cnt = 0;
    stall_seen    = 0;
    stall_done    = 0;
    img_width     = 16'(w);
    img_height    = 16'(h);
    start         = 1'b1;
    @(posedge tb_clk);
    #1;
    start = 1'b0;
    chk(busy == 1'b1, "busy_after_start", busy, 1);
    chk(size_err == 1'b0, "size_err_clear", size_err, 0);
    for (int k = 0; k < w * h; k++) begin
      if (abort_after > 0 && k == abort_after) begin
        chk_en = 0;
        n_rst  = 1'b0;
        #1;
        chk(pixel_ready == 1'b0, "rst_mid_pixel_ready", pixel_ready, 0);
        chk(window_valid == 1'b0, "rst_mid_window_valid", window_valid, 0);
        chk(window_data == 72'h0, "rst_mid_window_data", window_data, 0);
        chk(busy == 1'b0, "rst_mid_busy", busy, 0);
        chk(frame_done == 1'b0, "rst_mid_frame_done", frame_done, 0);
        chk(size_err == 1'b0, "rst_mid_size_err", size_err, 0);
        exp_q.delete();
        prev_hold = 0;
        @(posedge tb_clk);
        #1;
        n_rst  = 1'b1;
        chk_en = 1;
        repeat (3) @(posedge tb_clk);
        #1;
        chk(done_pulses == d0, "rst_no_frame_done", done_pulses, d0);
        return;
      end
      if (gaps && $urandom_range(0, 3) == 0) begin
        pixel_valid = 1'b0;
        pixel_data  = 24'($urandom);
        @(posedge tb_clk);
        #1;
      end
      if (spurious && k == 3) begin
        start      = 1'b1;
        img_width  = 16'd9;
        img_height = 16'd9;
        @(posedge tb_clk);
        #1;
        start = 1'b0;
      end
      send_pixel(img[k]);
    end
    n = 0;
    while (done_pulses == d0 && n < 200) begin
      @(negedge tb_clk);
      #1;
      n++;
    end
    chk(done_pulses == d0 + 1, "frame_done_seen", done_pulses - d0, 1);
    @(posedge tb_clk);
    #1;
    chk(busy == 1'b0, "busy_after_done", busy, 0);
    chk(frame_done == 1'b0, "frame_done_one_cycle", frame_done, 0);
    chk(exp_q.size() == 0, "windows_missing", exp_q.size(), 0);
  endtask

  task automatic run_bad(input int w, input int h);
    int d0;
    int seen;
    exp_q.delete();
    d0            = done_pulses;
    seen          = 0;
    frame_win_cnt = 0;
    img_width     = 16'(w);
    img_height    = 16'(h);
    start         = 1'b1;
    pixel_valid   = 1'b1;
    pixel_data    = 24'($urandom);
    @(posedge tb_clk);
    #1;
    start = 1'b0;
    chk(size_err == 1'b1, "size_err_set", size_err, 1);
    repeat (2) begin
      @(negedge tb_clk);
      if (pixel_ready || window_valid) seen++;
    end
    #1;
    chk(done_pulses == d0 + 1, "size_err_frame_done", done_pulses - d0, 1);
    repeat (3) begin
      @(negedge tb_clk);
      if (pixel_ready || window_valid) seen++;
    end
    chk(seen == 0, "size_err_no_traffic", seen, 0);
    chk(frame_win_cnt == 0, "size_err_no_windows", frame_win_cnt, 0);
    @(posedge tb_clk);
    #1;
    pixel_valid = 1'b0;
    chk(size_err == 1'b1, "size_err_sticky", size_err, 1);
    chk(busy == 1'b0, "size_err_idle", busy, 0);
  endtask

  initial begin
    n_rst       = 1'b0;
    start       = 1'b0;
    img_width   = '0;
    img_height  = '0;
    pixel_valid = 1'b0;
    pixel_data  = '0;
    rdy_mode    = 0;
    repeat (3) @(posedge tb_clk);
    #1;
    chk(pixel_ready == 1'b0, "rst_pixel_ready", pixel_ready, 0);
    chk(window_valid == 1'b0, "rst_window_valid", window_valid, 0);
    chk(window_data == 72'h0, "rst_window_data", window_data, 0);
    chk(busy == 1'b0, "rst_busy", busy, 0);
    chk(frame_done == 1'b0, "rst_frame_done", frame_done, 0);
    chk(size_err == 1'b0, "rst_size_err", size_err, 0);
    n_rst  = 1'b1;
    chk_en = 1;
    @(posedge tb_clk);
    #1;

    chk(gray_of(24'h4080C0) == 8'h80, "model_gray_4080c0", gray_of(24'h4080C0), 8'h80);
    chk(gray_of(24'hFFFFFF) == 8'hFF, "model_gray_ffffff", gray_of(24'hFFFFFF), 8'hFF);

    // 3x3 frame: single window of the nine converted values.
    img.delete();
    img.push_back(24'h4080C0);
    img.push_back(24'hFFFFFF);
    for (int k = 2; k < 9; k++) img.push_back({8'(k), 8'(k), 8'(k)});
    rdy_mode = 0;
    run_frame(3, 3, 0, 0, 0);
    chk(frame_win_cnt == 1, "f3x3_count", frame_win_cnt, 1);
    chk(first_win == 72'h80FF02030405060708, "f3x3_window", first_win, 72'h80FF02030405060708);

    // 4x4 ramp, ready tied high.
    gen_ramp(4, 4);
    run_frame(4, 4, 0, 0, 0);
    chk(frame_win_cnt == 4, "f4x4_count", frame_win_cnt, 4);
    chk(first_win == 72'h00010204050608090A, "f4x4_first", first_win, 72'h00010204050608090A);
    chk(last_win == 72'h050607090A0B0D0E0F, "f4x4_last", last_win, 72'h050607090A0B0D0E0F);

    // Same frame with a 5-cycle stall on the first window.
    rdy_mode = 2;
    run_frame(4, 4, 0, 0, 0);
    chk(stall_seen >= 5, "bp_stall_cycles", stall_seen, 5);
    chk(frame_win_cnt == 4, "bp_count", frame_win_cnt, 4);
    chk(first_win == 72'h00010204050608090A, "bp_first", first_win, 72'h00010204050608090A);
    chk(last_win == 72'h050607090A0B0D0E0F, "bp_last", last_win, 72'h050607090A0B0D0E0F);
    rdy_mode = 0;

    // Bad dimensions.
    run_bad(2, 10);
    run_bad(2501, 3);
    run_bad(5, 2);

    // Reset part-way through a 5x5 frame, then a clean 5x5 frame.
    rdy_mode = 1;
    gen_rand(5, 5);
    run_frame(5, 5, 0, 7, 0);
    gen_rand(5, 5);
    run_frame(5, 5, 1, 0, 0);
    chk(frame_win_cnt == 9, "f5x5_count", frame_win_cnt, 9);

    // Spurious start while busy, then 3x8 starting right after frame_done.
    gen_rand(4, 5);
    run_frame(4, 5, 1, 0, 1);
    chk(frame_win_cnt == 6, "spurious_count", frame_win_cnt, 6);
    gen_rand(3, 8);
    run_frame(3, 8, 0, 0, 0);
    chk(frame_win_cnt == 6, "f3x8_count", frame_win_cnt, 6);

    // Random frames.
    for (int t = 0; t < 4; t++) begin
      int w;
      int h;
      w = $urandom_range(3, 12);
      h = $urandom_range(3, 7);
      gen_rand(w, h);
      run_frame(w, h, 1, 0, 0);
      chk(frame_win_cnt == (w - 2) * (h - 2), "rand_count", frame_win_cnt, (w - 2) * (h - 2));
    end

    // Widest legal frame.
    rdy_mode = 0;
    gen_rand(2500, 3);
    run_frame(2500, 3, 0, 0, 0);
    chk(frame_win_cnt == 2498, "max_width_count", frame_win_cnt, 2498);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
